// File: rtl/uart_single_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_single_frame_rx                                             |
// | Brief   : 8N1 UART receiver, LSB first, 1-cycle data_valid/frame_err pulse |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_single_frame_rx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] c_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] c_LAST = IW'(DATA_BITS - 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_START = 3'd1;
  localparam logic [2:0] c_DATA  = 3'd2;
  localparam logic [2:0] c_STOP  = 3'd3;
  localparam logic [2:0] c_BREAK = 3'd4;

  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [CW-1:0]        r_clk_cnt;
  logic [IW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_data_valid;
  logic                 r_frame_err;
  logic                 w_half;
  logic                 w_full;
  logic                 w_bit_done;
  logic                 w_dv_set;
  logic                 w_fe_set;
  logic                 w_busy;

  assign w_half = (r_clk_cnt == c_HALF);
  assign w_full = (r_clk_cnt == c_FULL);

  // Synchroniser presets to the idle-high line level so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (!r_rx_s) w_state_nxt = c_START;
      c_START: if (w_half) w_state_nxt = r_rx_s ? c_IDLE : c_DATA;
      c_DATA:  if (w_full && (r_bit_idx == c_LAST)) w_state_nxt = c_STOP;
      c_STOP:  if (w_full) w_state_nxt = r_rx_s ? c_IDLE : c_BREAK;
      c_BREAK: if (r_rx_s) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = (r_state != c_IDLE);
    w_bit_done = (r_state == c_DATA) && w_full;
    w_dv_set   = (r_state == c_STOP) && w_full && r_rx_s;
    w_fe_set   = (r_state == c_STOP) && w_full && !r_rx_s;
  end

  // Bit timer restarts on every state change and on each data-bit sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if ((r_state != w_state_nxt) || w_bit_done)
        r_clk_cnt <= '0;
      else if (!w_full)
        r_clk_cnt <= r_clk_cnt + 1'b1;

      if ((r_state == c_START) && (w_state_nxt == c_DATA))
        r_bit_idx <= '0;
      else if (w_bit_done)
        r_bit_idx <= r_bit_idx + 1'b1;

      if (w_bit_done)
        r_shift[r_bit_idx] <= r_rx_s;

      r_data_valid <= w_dv_set;
      r_frame_err  <= w_fe_set;
      if (w_dv_set)
        r_data <= r_shift;
    end
  end

  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_single_frame_rx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_single_frame_rx                                          |
// | Brief   : Directed self-checking bench for uart_single_frame_rx (16 clk/bit)|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_single_frame_rx;

  localparam int c_CPB    = 16;
  localparam int c_CLK_NS = 10;
  localparam int c_BIT_NS = c_CPB * c_CLK_NS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  uart_single_frame_rx #(.CLKS_PER_BIT(c_CPB), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data),
    .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
  );

  always #(c_CLK_NS / 2) clk = ~clk;

  int       cyc = 0;
  int       dv_cnt = 0, fe_cnt = 0, overlap_cnt = 0, busy_cyc = 0;
  int       dv_cyc = 0, prev_dv_cyc = 0;
  int       dv_run = 0, fe_run = 0, max_dv_run = 0, max_fe_run = 0;
  logic [7:0] last_data = 8'h00, prev_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts, captured bytes, pulse widths and overlap
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt      <= dv_cnt + 1;
      last_data   <= data;
      prev_data   <= last_data;
      dv_cyc      <= cyc;
      prev_dv_cyc <= dv_cyc;
      dv_run      <= dv_run + 1;
      if (dv_run + 1 > max_dv_run) max_dv_run <= dv_run + 1;
    end else begin
      dv_run <= 0;
    end
    if (frame_err) begin
      fe_cnt <= fe_cnt + 1;
      fe_run <= fe_run + 1;
      if (fe_run + 1 > max_fe_run) max_fe_run <= fe_run + 1;
    end else begin
      fe_run <= 0;
    end
    if (data_valid && frame_err) overlap_cnt <= overlap_cnt + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    idle(3);
    tests_run++;
    if (data !== 8'h00) begin tests_failed++; $display("FAIL reset_data got=%h exp=00", data); end
    tests_run++;
    if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_dv got=%b exp=0", data_valid); end
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_fe got=%b exp=0", frame_err); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    int dv0, fe0, t_fall, lat;
    idle(50);
    dv0 = dv_cnt; fe0 = fe_cnt;
    align();
    t_fall = cyc;
    send_frame(8'h41, 1'b1, c_BIT_NS);
    idle(1);
    lat = dv_cyc - t_fall;
    tests_run++;
    if (dv_cnt - dv0 !== 1) begin tests_failed++; $display("FAIL single_dv_count got=%0d exp=1", dv_cnt - dv0); end
    tests_run++;
    if (data !== 8'h41) begin tests_failed++; $display("FAIL single_data got=%h exp=41", data); end
    tests_run++;
    if (fe_cnt - fe0 !== 0) begin tests_failed++; $display("FAIL single_fe_count got=%0d exp=0", fe_cnt - fe0); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_after got=%b exp=0", busy); end
    tests_run++;
    if (lat < 154 || lat > 156) begin tests_failed++; $display("FAIL single_latency got=%0d exp=155+/-1", lat); end
  endtask

  task automatic test_back_to_back();
    int dv0;
    idle(10);
    dv0 = dv_cnt;
    align();
    send_frame(8'h42, 1'b1, c_BIT_NS);
    send_frame(8'h43, 1'b1, c_BIT_NS);
    idle(2);
    tests_run++;
    if (dv_cnt - dv0 !== 2) begin tests_failed++; $display("FAIL b2b_dv_count got=%0d exp=2", dv_cnt - dv0); end
    tests_run++;
    if (prev_data !== 8'h42) begin tests_failed++; $display("FAIL b2b_first got=%h exp=42", prev_data); end
    tests_run++;
    if (last_data !== 8'h43) begin tests_failed++; $display("FAIL b2b_second got=%h exp=43", last_data); end
    tests_run++;
    if (dv_cyc - prev_dv_cyc !== 160) begin tests_failed++; $display("FAIL b2b_spacing got=%0d exp=160", dv_cyc - prev_dv_cyc); end
  endtask

  task automatic test_false_start();
    int dv0, fe0, b0;
    idle(10);
    dv0 = dv_cnt; fe0 = fe_cnt; b0 = busy_cyc;
    align();
    rx = 1'b0;
    #(4 * c_CLK_NS);
    rx = 1'b1;
    idle(30);
    tests_run++;
    if (dv_cnt - dv0 !== 0) begin tests_failed++; $display("FAIL false_dv got=%0d exp=0", dv_cnt - dv0); end
    tests_run++;
    if (fe_cnt - fe0 !== 0) begin tests_failed++; $display("FAIL false_fe got=%0d exp=0", fe_cnt - fe0); end
    tests_run++;
    if (busy_cyc - b0 < 1 || busy_cyc - b0 > 8) begin
      tests_failed++; $display("FAIL false_busy_cycles got=%0d exp=1..8", busy_cyc - b0);
    end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL false_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_frame_error();
    int dv0, fe0;
    idle(10);
    align();
    send_frame(8'h41, 1'b1, c_BIT_NS);
    idle(5);
    dv0 = dv_cnt; fe0 = fe_cnt;
    align();
    rx = 1'b0;
    #(c_BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx = (8'h7E >> i) & 8'h01;
      #(c_BIT_NS);
    end
    rx = 1'b0;
    #(c_BIT_NS);
    #(40 * c_CLK_NS);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL ferr_busy_while_low got=%b exp=1", busy); end
    rx = 1'b1;
    idle(10);
    tests_run++;
    if (fe_cnt - fe0 !== 1) begin tests_failed++; $display("FAIL ferr_fe_count got=%0d exp=1", fe_cnt - fe0); end
    tests_run++;
    if (dv_cnt - dv0 !== 0) begin tests_failed++; $display("FAIL ferr_dv_count got=%0d exp=0", dv_cnt - dv0); end
    tests_run++;
    if (data !== 8'h41) begin tests_failed++; $display("FAIL ferr_data_held got=%h exp=41", data); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL ferr_busy_release got=%b exp=0", busy); end
    align();
    send_frame(8'h55, 1'b1, c_BIT_NS);
    idle(2);
    tests_run++;
    if (data !== 8'h55 || dv_cnt - dv0 !== 1) begin
      tests_failed++; $display("FAIL ferr_recover got=%h/%0d exp=55/1", data, dv_cnt - dv0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int dv0;
    idle(10);
    dv0 = dv_cnt;
    align();
    rx = 1'b0;
    #(c_BIT_NS);
    rx = 1'b1; #(c_BIT_NS);
    rx = 1'b0; #(c_BIT_NS);
    rx = 1'b1; #(c_BIT_NS);
    #(c_BIT_NS / 2);
    rst_n = 1'b0;
    #2;
    tests_run++;
    if ({data, data_valid, frame_err, busy} !== 11'd0) begin
      tests_failed++;
      $display("FAIL midrst_outputs got=%h/%b/%b/%b exp=00/0/0/0", data, data_valid, frame_err, busy);
    end
    rx = 1'b1;
    idle(5);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    tests_run++;
    if (dv_cnt - dv0 !== 0) begin tests_failed++; $display("FAIL midrst_no_pulse got=%0d exp=0", dv_cnt - dv0); end
    align();
    send_frame(8'hA5, 1'b1, c_BIT_NS);
    idle(2);
    tests_run++;
    if (data !== 8'hA5 || dv_cnt - dv0 !== 1) begin
      tests_failed++; $display("FAIL midrst_next_frame got=%h/%0d exp=a5/1", data, dv_cnt - dv0);
    end
  endtask

  // Bit periods of 15.4 and 16.6 clocks exercise the baud-mismatch margin
  task automatic test_tolerance();
    int          periods [2];
    logic [7:0]  bytes [3];
    int          dv0, fe0;
    periods[0] = 154; periods[1] = 166;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h5A;
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 3; b++) begin
        idle(20);
        dv0 = dv_cnt; fe0 = fe_cnt;
        align();
        send_frame(bytes[b], 1'b1, periods[p]);
        idle(3);
        tests_run++;
        if (data !== bytes[b] || dv_cnt - dv0 !== 1 || fe_cnt - fe0 !== 0) begin
          tests_failed++;
          $display("FAIL tol_%0dns_byte%0d got=%h dv=%0d fe=%0d exp=%h dv=1 fe=0",
                   periods[p], b, data, dv_cnt - dv0, fe_cnt - fe0, bytes[b]);
        end
      end
    end
  endtask

  task automatic test_pulse_shape();
    tests_run++;
    if (max_dv_run !== 1) begin tests_failed++; $display("FAIL dv_width got=%0d exp=1", max_dv_run); end
    tests_run++;
    if (max_fe_run !== 1) begin tests_failed++; $display("FAIL fe_width got=%0d exp=1", max_fe_run); end
    tests_run++;
    if (overlap_cnt !== 0) begin tests_failed++; $display("FAIL dv_fe_overlap got=%0d exp=0", overlap_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_error();
    test_reset_mid_frame();
    test_tolerance();
    test_pulse_shape();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
